// File: rtl/mos6502_pkg.sv
// Shared types for the 6502 load/store core: state encoding, addressing modes,
// register selectors and the opcodes the decoder recognises.
package mos6502_pkg;

    typedef enum logic [2:0] {
        RESET, FETCH, IMM, ZP, ABSL, ABSH, DATA, NOP
    } state_t;

    typedef enum logic [2:0] {
        MODE_NONE, MODE_IMM, MODE_ZP, MODE_ABS, MODE_ABSX, MODE_ABSY
    } mode_t;

    typedef enum logic [1:0] {
        REG_A, REG_X, REG_Y
    } reg_sel_t;

    typedef struct packed {
        mode_t    mode;
        logic     is_load;
        logic     is_store;
        reg_sel_t reg_sel;
    } dec_t;

    localparam logic [7:0] OP_LDA_IMM  = 8'hA9;
    localparam logic [7:0] OP_LDA_ZP   = 8'hA5;
    localparam logic [7:0] OP_LDA_ABS  = 8'hAD;
    localparam logic [7:0] OP_LDA_ABSX = 8'hBD;
    localparam logic [7:0] OP_LDA_ABSY = 8'hB9;
    localparam logic [7:0] OP_LDX_IMM  = 8'hA2;
    localparam logic [7:0] OP_LDX_ZP   = 8'hA6;
    localparam logic [7:0] OP_LDX_ABS  = 8'hAE;
    localparam logic [7:0] OP_LDX_ABSY = 8'hBE;
    localparam logic [7:0] OP_LDY_IMM  = 8'hA0;
    localparam logic [7:0] OP_LDY_ZP   = 8'hA4;
    localparam logic [7:0] OP_LDY_ABS  = 8'hAC;
    localparam logic [7:0] OP_LDY_ABSX = 8'hBC;
    localparam logic [7:0] OP_STA_ZP   = 8'h85;
    localparam logic [7:0] OP_STA_ABS  = 8'h8D;
    localparam logic [7:0] OP_STA_ABSX = 8'h9D;
    localparam logic [7:0] OP_STA_ABSY = 8'h99;
    localparam logic [7:0] OP_STX_ZP   = 8'h86;
    localparam logic [7:0] OP_STX_ABS  = 8'h8E;
    localparam logic [7:0] OP_STY_ZP   = 8'h84;
    localparam logic [7:0] OP_STY_ABS  = 8'h8C;
    localparam logic [7:0] OP_NOP      = 8'hEA;

    localparam dec_t DEC_NOP = '{MODE_NONE, 1'b0, 1'b0, REG_A};

endpackage

// File: rtl/mos6502_ldst_decode.sv
// Combinational opcode decoder; anything not in the load/store table decodes as NOP.
module mos6502_ldst_decode
    import mos6502_pkg::*;
#(
    parameter bit INDEX_EN = 1'b1
) (
    input  logic [7:0] opcode,
    output dec_t       dec
);

    dec_t raw;

    always_comb begin
        raw = DEC_NOP;
        case (opcode)
            OP_LDA_IMM:  raw = '{MODE_IMM,  1'b1, 1'b0, REG_A};
            OP_LDA_ZP:   raw = '{MODE_ZP,   1'b1, 1'b0, REG_A};
            OP_LDA_ABS:  raw = '{MODE_ABS,  1'b1, 1'b0, REG_A};
            OP_LDA_ABSX: raw = '{MODE_ABSX, 1'b1, 1'b0, REG_A};
            OP_LDA_ABSY: raw = '{MODE_ABSY, 1'b1, 1'b0, REG_A};
            OP_LDX_IMM:  raw = '{MODE_IMM,  1'b1, 1'b0, REG_X};
            OP_LDX_ZP:   raw = '{MODE_ZP,   1'b1, 1'b0, REG_X};
            OP_LDX_ABS:  raw = '{MODE_ABS,  1'b1, 1'b0, REG_X};
            OP_LDX_ABSY: raw = '{MODE_ABSY, 1'b1, 1'b0, REG_X};
            OP_LDY_IMM:  raw = '{MODE_IMM,  1'b1, 1'b0, REG_Y};
            OP_LDY_ZP:   raw = '{MODE_ZP,   1'b1, 1'b0, REG_Y};
            OP_LDY_ABS:  raw = '{MODE_ABS,  1'b1, 1'b0, REG_Y};
            OP_LDY_ABSX: raw = '{MODE_ABSX, 1'b1, 1'b0, REG_Y};
            OP_STA_ZP:   raw = '{MODE_ZP,   1'b0, 1'b1, REG_A};
            OP_STA_ABS:  raw = '{MODE_ABS,  1'b0, 1'b1, REG_A};
            OP_STA_ABSX: raw = '{MODE_ABSX, 1'b0, 1'b1, REG_A};
            OP_STA_ABSY: raw = '{MODE_ABSY, 1'b0, 1'b1, REG_A};
            OP_STX_ZP:   raw = '{MODE_ZP,   1'b0, 1'b1, REG_X};
            OP_STX_ABS:  raw = '{MODE_ABS,  1'b0, 1'b1, REG_X};
            OP_STY_ZP:   raw = '{MODE_ZP,   1'b0, 1'b1, REG_Y};
            OP_STY_ABS:  raw = '{MODE_ABS,  1'b0, 1'b1, REG_Y};
            default:     raw = DEC_NOP;
        endcase

        dec = raw;
        if (!INDEX_EN && (raw.mode == MODE_ABSX || raw.mode == MODE_ABSY))
            dec = DEC_NOP;
    end

endmodule

// File: rtl/mos6502_ldst_core.sv
// 6502 load/store subset: LDA/LDX/LDY/STA/STX/STY over imm, zp, abs, abs,X, abs,Y
// with N/Z flags, rdy stall and sync strobe. Write data is 'wdata' since 'do' is a keyword.
module mos6502_ldst_core
    import mos6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  ZP_BASE  = 8'h00,
    parameter bit          INDEX_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [7:0]  di,
    output logic [7:0]  wdata,
    output logic [15:0] ab,
    output logic        we,
    output logic        sync,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_x,
    output logic [7:0]  reg_y,
    output logic        flag_n,
    output logic        flag_z
);

    state_t      state, state_nxt;
    dec_t        dec_fetch, ir;
    logic [15:0] pc;
    logic [7:0]  adl, adh;
    logic [7:0]  index, src;
    logic [15:0] eff;
    logic        load_en;

    mos6502_ldst_decode #(.INDEX_EN(INDEX_EN)) u_decode (
        .opcode (di),
        .dec    (dec_fetch)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RESET;
        else if (rdy)
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = FETCH;
        case (state)
            RESET: state_nxt = FETCH;
            FETCH: begin
                case (dec_fetch.mode)
                    MODE_IMM:                      state_nxt = IMM;
                    MODE_ZP:                       state_nxt = ZP;
                    MODE_ABS, MODE_ABSX, MODE_ABSY: state_nxt = ABSL;
                    default:                       state_nxt = NOP;
                endcase
            end
            IMM:     state_nxt = FETCH;
            ZP:      state_nxt = DATA;
            ABSL:    state_nxt = ABSH;
            ABSH:    state_nxt = DATA;
            DATA:    state_nxt = FETCH;
            NOP:     state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        case (ir.reg_sel)
            REG_X:   src = reg_x;
            REG_Y:   src = reg_y;
            default: src = reg_a;
        endcase
    end

    // Bus outputs depend only on registered state, never on di.
    always_comb begin
        ab    = pc;
        we    = 1'b0;
        wdata = 8'h00;
        sync  = 1'b0;
        case (state)
            FETCH: sync = 1'b1;
            DATA: begin
                ab = {adh, adl};
                if (ir.is_store) begin
                    wdata = src;
                    we    = rdy;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ir.mode)
            MODE_ABSX: index = reg_x;
            MODE_ABSY: index = reg_y;
            default:   index = 8'h00;
        endcase
    end

    assign eff     = {di, adl} + {8'h00, index};
    assign load_en = (state == IMM) || (state == DATA && ir.is_load);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= DEC_NOP;
            adl    <= 8'h00;
            adh    <= 8'h00;
            reg_a  <= 8'h00;
            reg_x  <= 8'h00;
            reg_y  <= 8'h00;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else if (rdy) begin
            case (state)
                FETCH: begin
                    ir <= dec_fetch;
                    pc <= pc + 16'd1;
                end
                IMM: pc <= pc + 16'd1;
                ZP: begin
                    adl <= di;
                    adh <= ZP_BASE;
                    pc  <= pc + 16'd1;
                end
                ABSL: begin
                    adl <= di;
                    pc  <= pc + 16'd1;
                end
                ABSH: begin
                    {adh, adl} <= eff;
                    pc         <= pc + 16'd1;
                end
                default: ;
            endcase

            if (load_en) begin
                case (ir.reg_sel)
                    REG_X:   reg_x <= di;
                    REG_Y:   reg_y <= di;
                    default: reg_a <= di;
                endcase
                flag_n <= di[7];
                flag_z <= (di == 8'h00);
            end
        end
    end

endmodule
